// File: rtl/fft4_frame_ctrl.sv
// fft4_frame_ctrl
// Frame sequencer for the 2-stage pipelined 4-point FFT core.
// Collects four complex samples into a frame buffer that drives the core.
// Waits out the core latency, then captures the four bins. The bins are
// streamed out in bin order with backpressure. The next frame may load
// while the current results drain.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and data stable until the transfer. The controller
// never drops a sample and never reads data while its ready is low. The
// out_valid/out_data pair stays stable until it is accepted. out_ready is
// ignored while out_valid is low.
//
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   clear                       synchronous abort of partial frame and results
//   in_valid/in_ready           sample handshake; in_real/in_imag sample data
//   core_x_real/core_x_imag     frame buffer to core, x_k at [k*W +: W]
//   core_y_real/core_y_imag     core bins, y_k at [k*W +: W]
//   out_valid/out_ready         bin handshake; out_real/out_imag bin data
//   out_index, out_last         bin number, high with bin 3
//   frame_done                  one-cycle pulse following a capture
//   busy                        low only when idle with an empty frame buffer
//   dbg_state                   current FSM state (LOAD=0 WAIT=1 CAPTURE=2 DRAIN=3)
module fft4_frame_ctrl #(
    parameter int W        = 4,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_real,
    input  logic [W-1:0]   in_imag,
    output logic [4*W-1:0] core_x_real,
    output logic [4*W-1:0] core_x_imag,
    input  logic [4*W-1:0] core_y_real,
    input  logic [4*W-1:0] core_y_imag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_real,
    output logic [W-1:0]   out_imag,
    output logic [1:0]     out_index,
    output logic           out_last,
    output logic           frame_done,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(CORE_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(CORE_LAT);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_wait_nxt;
    logic [2:0]      r_wr_cnt;
    logic [2:0]      w_wr_nxt;
    logic [2:0]      w_wr_inc;
    logic [1:0]      r_rd_idx;
    logic [1:0]      w_rd_nxt;
    logic [4*W-1:0]  r_buf_real;
    logic [4*W-1:0]  r_buf_imag;
    logic [4*W-1:0]  r_res_real;
    logic [4*W-1:0]  r_res_imag;
    logic            r_frame_done;
    logic            w_capture;
    logic            w_in_fire;
    logic            w_out_fire;

    // In DRAIN the next frame may load until the buffer is full.
    assign in_ready   = (r_state == S_LOAD) ||
                        ((r_state == S_DRAIN) && (r_wr_cnt < 3'd4));
    assign out_valid  = (r_state == S_DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_wr_inc   = r_wr_cnt + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_wr_nxt    = r_wr_cnt;
        w_rd_nxt    = r_rd_idx;
        w_capture   = 1'b0;
        if (w_in_fire) begin
            w_wr_nxt = w_wr_inc;
        end
        if (w_out_fire) begin
            w_rd_nxt = r_rd_idx + 2'd1;
        end
        case (r_state)
            S_LOAD: begin
                if (w_in_fire && (w_wr_inc == 3'd4)) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = LAT;
                end
            end
            S_WAIT: begin
                w_wait_nxt = r_wait_cnt - CW'(1);
                if (r_wait_cnt == CW'(1)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_wr_nxt    = 3'd0;
                w_rd_nxt    = 2'd0;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // The bin-3 transfer ends the drain. A full next frame,
                // even one completed on this very edge, goes straight to WAIT.
                if (w_out_fire && (r_rd_idx == 2'd3)) begin
                    if (w_wr_nxt == 3'd4) begin
                        w_state_nxt = S_WAIT;
                        w_wait_nxt  = LAT;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_LOAD;
            r_wait_cnt   <= '0;
            r_wr_cnt     <= 3'd0;
            r_rd_idx     <= 2'd0;
            r_frame_done <= 1'b0;
            r_buf_real   <= '0;
            r_buf_imag   <= '0;
            r_res_real   <= '0;
            r_res_imag   <= '0;
        end else if (clear) begin
            // Abort wins over any transfer this cycle; buffers keep contents.
            r_state      <= S_LOAD;
            r_wait_cnt   <= '0;
            r_wr_cnt     <= 3'd0;
            r_rd_idx     <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_wr_cnt     <= w_wr_nxt;
            r_rd_idx     <= w_rd_nxt;
            r_frame_done <= w_capture;
            if (w_in_fire) begin
                r_buf_real[r_wr_cnt[1:0]*W +: W] <= in_real;
                r_buf_imag[r_wr_cnt[1:0]*W +: W] <= in_imag;
            end
            if (w_capture) begin
                r_res_real <= core_y_real;
                r_res_imag <= core_y_imag;
            end
        end
    end

    assign core_x_real = r_buf_real;
    assign core_x_imag = r_buf_imag;
    assign out_real    = r_res_real[r_rd_idx*W +: W];
    assign out_imag    = r_res_imag[r_rd_idx*W +: W];
    assign out_index   = r_rd_idx;
    assign out_last    = out_valid && (r_rd_idx == 2'd3);
    assign frame_done  = r_frame_done;
    assign busy        = !((r_state == S_LOAD) && (r_wr_cnt == 3'd0));
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fft4_frame_ctrl.sv
// tb_fft4_frame_ctrl
// Bench for fft4_frame_ctrl. A behavioural stand-in for the FFT core sits
// beside the controller. The controller is checked every cycle against a
// transaction-level model: samples accepted, frames in flight, and the
// queue of expected bins.
module tb_fft4_frame_ctrl;
    localparam int W        = 4;
    localparam int CORE_LAT = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           clear = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_real = '0;
    logic [W-1:0]   in_imag = '0;
    logic           in_ready;
    logic [4*W-1:0] core_x_real, core_x_imag, core_y_real, core_y_imag;
    logic           out_valid;
    logic [W-1:0]   out_real, out_imag;
    logic [1:0]     out_index;
    logic           out_last, frame_done, busy;
    logic [1:0]     dbg_state;

    fft4_frame_ctrl #(.W(W), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .core_x_real(core_x_real), .core_x_imag(core_x_imag),
        .core_y_real(core_y_real), .core_y_imag(core_y_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last),
        .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Plain 4-point DFT: y_k = sum_n x_n * exp(-j*pi/2*n*k), wrapped to W bits.
    function automatic logic [8*W-1:0] dft4(input logic [4*W-1:0] xr, input logic [4*W-1:0] xi);
        int wre[4];
        int wim[4];
        int r[4];
        int im[4];
        int ar, ai, m;
        logic [4*W-1:0] pr, pi;
        wre = '{1, 0, -1, 0};
        wim = '{0, -1, 0, 1};
        for (int n = 0; n < 4; n++) begin
            r[n]  = int'($signed(xr[n*W +: W]));
            im[n] = int'($signed(xi[n*W +: W]));
        end
        for (int k = 0; k < 4; k++) begin
            ar = 0;
            ai = 0;
            for (int n = 0; n < 4; n++) begin
                m  = (n * k) % 4;
                ar = ar + r[n] * wre[m] - im[n] * wim[m];
                ai = ai + r[n] * wim[m] + im[n] * wre[m];
            end
            pr[k*W +: W] = W'(ar);
            pi[k*W +: W] = W'(ai);
        end
        return {pi, pr};
    endfunction

    // Core stand-in: CORE_LAT register stages behind a combinational DFT.
    logic [4*W-1:0] p1_r = '0, p1_i = '0, p2_r = '0, p2_i = '0;
    always @(posedge clk) begin
        {p1_i, p1_r} <= dft4(core_x_real, core_x_imag);
        p2_r <= p1_r;
        p2_i <= p1_i;
    end
    assign core_y_real = p2_r;
    assign core_y_imag = p2_i;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [W-1:0] m_fr_r[4];
    logic [W-1:0] m_fr_i[4];
    int           m_n = 0;
    int           m_flight = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] exp_r[$];
    logic [W-1:0] exp_i[$];
    // Bins actually transferred out of the DUT.
    logic [W-1:0] obs_r[$];
    logic [W-1:0] obs_i[$];
    bit           last_in_fire = 1'b0;
    bit           last_frame_done = 1'b0;
    bit           tog = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        m_flight = 0;
        m_done = 1'b0;
        exp_r.delete();
        exp_i.delete();
    endtask

    task automatic model_capture();
        logic [4*W-1:0] pr, pi;
        logic [8*W-1:0] y;
        pr = {m_fr_r[3], m_fr_r[2], m_fr_r[1], m_fr_r[0]};
        pi = {m_fr_i[3], m_fr_i[2], m_fr_i[1], m_fr_i[0]};
        y = dft4(pr, pi);
        for (int k = 0; k < 4; k++) begin
            exp_r.push_back(y[k*W +: W]);
            exp_i.push_back(y[4*W + k*W +: W]);
        end
    endtask

    // One clock: check outputs mid-cycle, let the edge happen, advance model.
    task automatic tick();
        bit exp_ready, in_fire, out_fire;
        int qs;
        @(negedge clk);
        qs = exp_r.size();
        exp_ready = (m_flight == 0) && (m_n < 4);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(qs != 0));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("busy", 32'(busy), 32'(!(qs == 0 && m_flight == 0 && m_n == 0)));
        if (qs != 0) begin
            check("out_real", 32'(out_real), 32'(exp_r[0]));
            check("out_imag", 32'(out_imag), 32'(exp_i[0]));
            check("out_index", 32'(out_index), 32'(4 - qs));
            check("out_last", 32'(out_last), 32'(qs == 1));
        end
        last_frame_done = frame_done;
        in_fire  = in_valid && exp_ready && !clear;
        out_fire = out_ready && (qs != 0) && !clear;
        if (out_valid && out_ready && !clear) begin
            obs_r.push_back(out_real);
            obs_i.push_back(out_imag);
        end
        last_in_fire = in_fire;
        @(posedge clk);
        #1;
        if (clear) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_flight == 1) begin
                model_capture();
                m_n = 0;
                m_flight = 0;
                m_done = 1'b1;
            end else if (m_flight > 1) begin
                m_flight--;
            end
            if (out_fire) begin
                void'(exp_r.pop_front());
                void'(exp_i.pop_front());
            end
            if (in_fire) begin
                m_fr_r[m_n] = in_real;
                m_fr_i[m_n] = in_imag;
                m_n++;
            end
            // A full frame enters the core once the previous results are gone.
            if (m_n == 4 && m_flight == 0 && exp_r.size() == 0 && !m_done)
                m_flight = CORE_LAT + 1;
        end
        if (tog) out_ready = !out_ready;
    endtask

    task automatic send(input logic [W-1:0] r, input logic [W-1:0] i);
        int n;
        in_valid = 1'b1;
        in_real = r;
        in_imag = i;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_in_fire && n < 60);
        check("send_accepted", 32'(last_in_fire), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_r.size() != 0 || m_flight != 0) && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", 32'(exp_r.size() == 0 && m_flight == 0), 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (exp_r.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(exp_r.size() != 0), 32'd1);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_real", 32'(out_real), 32'd0);
        check("rst_out_imag", 32'(out_imag), 32'd0);
        check("rst_core_x_real", 32'(core_x_real), 32'd0);
        check("rst_dbg_state", 32'(dbg_state), 32'd0);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] gr[4];
        logic [W-1:0] gi[4];
        logic [8*W-1:0] gy;
        logic [W-1:0] t2_r[4];
        logic [W-1:0] t2_i[4];
        int lat;

        // Reset state while reset_n is held low from time 0.
        #3;
        reset_pulse();
        @(posedge clk);
        #1;

        // 1. Impulse with latency measurement.
        out_ready = 1'b1;
        obs_r.delete(); obs_i.delete();
        send(4'd1, 4'd0);
        for (int k = 0; k < 3; k++) send(4'd0, 4'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!last_frame_done && lat < 10);
        // The tick that sees frame_done samples mid-cycle after edge E+lat-1.
        check("t1_frame_done_latency", 32'(lat - 1), 32'd3);
        drain();
        check("t1_bin_count", 32'(obs_r.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t1_bin_real", 32'(obs_r[k]), 32'd1);
            check("t1_bin_imag", 32'(obs_i[k]), 32'd0);
        end

        // 2. Wrap passthrough: real 1,2,3,4.
        obs_r.delete(); obs_i.delete();
        for (int k = 0; k < 4; k++) send(W'(k + 1), 4'd0);
        drain();
        t2_r = '{4'hA, 4'hE, 4'hE, 4'hE};
        t2_i = '{4'h0, 4'h2, 4'h0, 4'hE};
        check("t2_bin_count", 32'(obs_r.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t2_bin_real", 32'(obs_r[k]), 32'(t2_r[k]));
            check("t2_bin_imag", 32'(obs_i[k]), 32'(t2_i[k]));
        end

        // 3. Backpressure: hold bin 0 for 5 cycles, then 4 back-to-back transfers.
        out_ready = 1'b0;
        obs_r.delete(); obs_i.delete();
        for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        wait_valid();
        repeat (5) tick();
        check("t3_no_early_transfer", 32'(obs_r.size()), 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        check("t3_four_transfers", 32'(obs_r.size()), 32'd4);
        drain();

        // 4. Overlap: next frame loads while results drain with toggling ready.
        out_ready = 1'b0;
        obs_r.delete(); obs_i.delete();
        for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        wait_valid();
        tog = 1'b1;
        for (int k = 0; k < 4; k++) send(4'd1, 4'd0);
        tog = 1'b0;
        drain();
        check("t4_bin_count", 32'(obs_r.size()), 32'd8);
        check("t4_bin0_real", 32'(obs_r[4]), 32'd4);
        check("t4_bin0_imag", 32'(obs_i[4]), 32'd0);
        for (int k = 5; k < 8; k++) begin
            check("t4_bin_real", 32'(obs_r[k]), 32'd0);
            check("t4_bin_imag", 32'(obs_i[k]), 32'd0);
        end

        // 5. Reset during WAIT, then a fresh frame.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        tick();
        reset_pulse();
        repeat (4) tick();
        obs_r.delete(); obs_i.delete();
        for (int k = 0; k < 4; k++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        drain();
        check("t5_bin_count", 32'(obs_r.size()), 32'd4);

        // 6. clear with wr_cnt=2 and a sample offered; then a golden frame.
        for (int k = 0; k < 2; k++) send(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        in_valid = 1'b1;
        in_real = 4'h7;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        tick();
        check("t6_idle_after_clear", 32'(busy), 32'd0);
        obs_r.delete(); obs_i.delete();
        for (int k = 0; k < 4; k++) begin
            gr[k] = W'($urandom_range(0, 15));
            gi[k] = W'($urandom_range(0, 15));
            send(gr[k], gi[k]);
        end
        drain();
        gy = dft4({gr[3], gr[2], gr[1], gr[0]}, {gi[3], gi[2], gi[1], gi[0]});
        check("t6_bin_count", 32'(obs_r.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check("t6_bin_real", 32'(obs_r[k]), 32'(gy[k*W +: W]));
            check("t6_bin_imag", 32'(obs_i[k]), 32'(gy[4*W + k*W +: W]));
        end

        // Random traffic with occasional aborts.
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_real   = W'($urandom_range(0, 15));
            in_imag   = W'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 63) == 0);
            tick();
        end
        clear = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft4_frame_ctrl.md
Name: fft4_frame_ctrl

Overview:
Frame sequencer for the 2-stage pipelined 4-point FFT core. It accepts a serial complex-sample stream with a valid/ready handshake and packs 4 samples into a frame buffer that drives the core inputs. It waits out the core latency, captures the 4 bins, and streams them out in bin order with backpressure. It sits between the sample source and the result consumer; the core is instantiated alongside it and free-runs.

Parameters:
W, 4, sample/bin component width (signed two's complement)
CORE_LAT, 2, core latency in clocks from stable inputs to valid outputs

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort: drop partial frame and pending results
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_real  in  W  sample real part
in_imag  in  W  sample imag part
core_x_real  out  4*W  frame buffer to core; x_k at [k*W +: W]
core_x_imag  out  4*W  as above, imag
core_y_real  in  4*W  core outputs; y_k at [k*W +: W]
core_y_imag  in  4*W  as above, imag
out_valid  out  1  result bin valid
out_ready  in  1  consumer accepts bin
out_real  out  W  bin real part
out_imag  out  W  bin imag part
out_index  out  2  bin number 0..3
out_last  out  1  high with bin 3
frame_done  out  1  one-cycle pulse on capture
busy  out  1  high in any state other than LOAD with wr_cnt==0

Behaviour:
- reset_n low (async): state=LOAD, wr_cnt=0, rd_idx=0, wait counter=0. Frame buffer and result buffer cleared to 0. All outputs 0 except in_ready=1.
- An input transfer occurs when in_valid&&in_ready. The sample is written to buf[wr_cnt], then wr_cnt increments. wr_cnt is 3 bits, range 0..4.
- An output transfer occurs when out_valid&&out_ready. Then rd_idx increments, wrapping 3->0.
- out_real/out_imag/out_index are driven from registers only: res[rd_idx] and rd_idx.
- FSM states:
  - LOAD: in_ready=1. On the transfer that makes wr_cnt=4, go to WAIT with counter=CORE_LAT.
  - WAIT: in_ready=0. Counter decrements each cycle. When counter==1, go to CAPTURE. The frame buffer is frozen.
  - CAPTURE: one cycle, in_ready=0. At the end of the cycle, latch core_y into res[0..3], pulse frame_done, set wr_cnt=0, set rd_idx=0, go to DRAIN.
  - DRAIN: out_valid=1 and out_last=(rd_idx==3). in_ready=(wr_cnt<4): the next frame loads into buf while results drain. On the transfer of bin 3: if wr_cnt==4 (including a 4th sample accepted in the same cycle), go to WAIT with counter=CORE_LAT; otherwise go to LOAD.
- Latency: last sample accepted at edge E -> res captured at edge E+CORE_LAT+1 -> out_valid high from that edge. With CORE_LAT=2, bin 0 appears 3 cycles after the last input edge.
- out_valid holds and data stays stable until accepted. out_ready while out_valid=0 is ignored.
- core_x_* is never modified during WAIT or CAPTURE.
- Arithmetic: none in the controller. Bins are passed through bit-exact; any wrap inside the core is visible unchanged.
- clear=1 (sync): same state as reset except the buffers retain their contents. clear wins over any simultaneous input or output transfer; neither is counted.
- in_valid is ignored while in_ready=0; no sample is ever dropped silently.
- Reset mid-operation: partial frames and undrained results are lost; no frame_done is issued.

Test Plan:
1. Impulse: stream (1,0),(0,0),(0,0),(0,0), out_ready=1 -> frame_done 3 cycles after the 4th input; bins 0..3 all (1,0); out_last on index 3.
2. Wrap passthrough: stream real 1,2,3,4, imag 0 -> bins (-6,0),(-2,2),(-2,0),(-2,-2). Bin 0 shows the 4-bit wrap of 10.
3. Backpressure: out_ready low for 5 cycles after out_valid rises -> bin 0 held stable with no index advance; then 4 consecutive transfers.
4. Overlap: next frame (1,0)x4 streamed during DRAIN with out_ready toggling -> second frame accepted without in_ready dropping until wr_cnt=4. Second output is (4,0),(0,0),(0,0),(0,0), and WAIT starts right after the first frame's bin 3 transfer.
5. Reset mid-WAIT: reset_n pulsed low after the 4th sample -> no frame_done, out_valid=0, in_ready=1 immediately, wr_cnt=0; a fresh frame works correctly.
6. clear during LOAD with wr_cnt=2 and in_valid=1 -> sample not taken; the next 4 samples form a complete frame whose outputs match a golden 4-point DFT.
